// File: rtl/neuron_spike_decoder_pkg.sv
// neuron_pkg: shared state encoding, default widths and spike-mode selectors
package neuron_pkg;
   typedef enum logic {IDLE, COUNT} state_t;
   localparam int CNT_W_DEF   = 8;
   localparam int WIN_W_DEF   = 8;
   localparam int SPIKE_LEVEL = 0;
   localparam int SPIKE_EDGE  = 1;
endpackage

// File: rtl/neuron_spike_decoder_if.sv
// neuron_spike_decoder_if: rate result valid/ready channel toward readout logic
interface neuron_spike_decoder_if
   import neuron_pkg::*;
#(parameter int CNT_W = CNT_W_DEF);
   logic [CNT_W-1:0] out_rate;
   logic             out_sat;
   logic             out_valid;
   logic             out_ready;
   modport master (output out_rate, out_sat, out_valid, input out_ready);
   modport slave (input out_rate, out_sat, out_valid, output out_ready);
endinterface

// File: rtl/neuron_sat_counter.sv
// neuron_sat_counter: saturating counter exposing its next value and sticky overflow flag
module neuron_sat_counter
   import neuron_pkg::*;
#(parameter int W = CNT_W_DEF) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_next,
   output logic         o_next_sat
);
   logic [W-1:0] r_cnt;
   logic         r_sat;
   logic         w_full;
   assign w_full     = &r_cnt;
   assign o_next     = (i_inc && !w_full) ? r_cnt + 1'b1 : r_cnt;
   assign o_next_sat = r_sat | (i_inc & w_full);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (i_clr) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else begin
         r_cnt <= o_next;
         r_sat <= o_next_sat;
      end
endmodule

// File: rtl/neuron_spike_decoder.sv
// neuron_spike_decoder: counts neuron spikes over back-to-back programmable windows
// and hands each window's rate to the readout over a valid/ready channel.
module neuron_spike_decoder
   import neuron_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int WIN_W     = WIN_W_DEF,
   parameter int EDGE_MODE = SPIKE_LEVEL
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          clear,
   input  logic                          spike_in,
   input  logic [WIN_W-1:0]              window_len,
   neuron_spike_decoder_if.master        bus,
   output logic                          overrun
);
   state_t           r_state, w_next_state;
   logic [WIN_W-1:0] r_win_cnt, r_win_len, w_len_in;
   logic [CNT_W-1:0] r_rate, w_next;
   logic             r_prev, r_sat, r_valid, r_overrun;
   logic             w_count, w_end, w_hit, w_next_sat;
   assign w_len_in = (window_len == '0) ? WIN_W'(1) : window_len;
   assign w_hit    = (EDGE_MODE == SPIKE_EDGE) ? spike_in & ~r_prev : spike_in;
   assign w_count  = (r_state == COUNT) && en;
   assign w_end    = w_count && (r_win_cnt == r_win_len - 1'b1);
   always_comb w_next_state = en ? COUNT : IDLE;
   // Counter is held clear outside an active window so every window starts at 0.
   neuron_sat_counter #(.W(CNT_W)) u_spike_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (clear | ~w_count | w_end),
      .i_inc      (w_hit),
      .o_next     (w_next),
      .o_next_sat (w_next_sat)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state   <= IDLE;
         r_win_cnt <= '0;
         r_win_len <= '0;
         r_prev    <= 1'b0;
         r_rate    <= '0;
         r_sat     <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_prev  <= spike_in;
         if (clear) begin
            r_win_cnt <= '0;
            r_win_len <= w_len_in;
            r_rate    <= '0;
            r_sat     <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
         end else begin
            if (r_valid && bus.out_ready) r_valid <= 1'b0;
            if (r_state == IDLE || w_end) begin
               r_win_cnt <= '0;
               r_win_len <= w_len_in;
            end else begin
               r_win_cnt <= r_win_cnt + 1'b1;
            end
            // A fresh result wins over a same-edge transfer; overwrite of an unread one is flagged.
            if (w_end) begin
               r_rate  <= w_next;
               r_sat   <= w_next_sat;
               r_valid <= 1'b1;
               if (r_valid && !bus.out_ready) r_overrun <= 1'b1;
            end
         end
      end
   assign bus.out_rate  = r_rate;
   assign bus.out_sat   = r_sat;
   assign bus.out_valid = r_valid;
   assign overrun       = r_overrun;
endmodule
